seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits (range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit is held (range 2 or more).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: when 1, seg and an drive 0 to light.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS: hex nibbles; nibble i feeds digit i (digit 0 is the LSB nibble).
REQ-007 SHALL have port dp_in, input, NUM_DIGITS: decimal point request per digit.
REQ-008 SHALL have port load, input, 1: capture value and dp_in into the pending register.
REQ-009 SHALL have port enable, input, 1: scan enable; 0 blanks the display.
REQ-010 SHALL have port lz_blank, input, 1: leading-zero suppression enable.
REQ-011 SHALL have port seg, output, 8: bits 0..6 are segments a..g, bit 7 is dp; registered.
REQ-012 SHALL have port an, output, NUM_DIGITS: one-hot digit select; registered.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse at scan wrap.

Function
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 while enable=1, then wrap; the terminal count is a "tick".
REQ-015 On a tick, the digit index SHALL advance; the index wraps NUM_DIGITS-1 -> 0.
REQ-016 frame_done SHALL be 1 for exactly the cycle after a tick that wraps the index to 0; otherwise 0.
REQ-017 load=1 SHALL capture value/dp_in into pending and set pending_valid; a later load before the boundary overwrites pending.
REQ-018 At the frame boundary (the tick wrapping the index to 0), pending SHALL be copied to shadow if pending_valid, then pending_valid is cleared.
REQ-019 If load=1 on the boundary cycle, the loaded value SHALL go directly to shadow and pending_valid SHALL end at 0.
REQ-020 Display SHALL read only shadow: no tearing mid-frame.
REQ-021 seg/an SHALL reflect the current index and shadow with exactly 1 cycle register latency.
REQ-022 Hex encoding (a..g, active-high form) SHALL be:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-023 seg[7] SHALL equal shadow dp bit of the current digit.
REQ-024 With lz_blank=1, digit i>0 SHALL have seg[6:0] off when shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be suppressed; dp SHALL be unaffected.
REQ-025 an SHALL have only the current-index bit active while enable=1.
REQ-026 When ACTIVE_LOW=1, both seg and an SHALL be the bitwise inverse of the active-high form.
REQ-027 enable=0 SHALL, from the next cycle, drive all an and seg inactive, hold the prescaler and index at 0, and suppress frame_done.
REQ-028 While enable=0, load SHALL still update pending.
REQ-029 Re-enable SHALL restart the scan at digit 0 with prescaler at 0.

Reset
REQ-030 rst=1 SHALL clear, on the next edge: prescaler, index, shadow, pending, pending_valid, and frame_done; it SHALL set seg and an inactive.
REQ-031 rst SHALL take priority over load and enable.
REQ-032 rst asserted mid-frame SHALL discard pending; after release, the scan restarts at digit 0.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-033 Reset, then load 16'h1234 with enable=1 -> after the first frame boundary: an=1110 seg=99, an=1101 seg=B0, an=1011 seg=A4, an=0111 seg=F9; each held 4 cycles.
REQ-034 Mid-frame load of 16'hABCD while index=2 -> digits 2 and 3 still show the old value; from the next index 0: seg=A1, C6, 83, 88.
REQ-035 value=16'h0050, lz_blank=1 -> digits 3 and 2 show seg=FF, digit 1 shows 92, digit 0 shows C0; with lz_blank=0, digits 3 and 2 show C0.
REQ-036 enable dropped mid-scan -> next cycle an=1111, seg=FF, frame_done stays 0; on re-enable, digit 0 is active for a full 4 cycles.
REQ-037 Free run -> frame_done is a one-cycle pulse every 16 cycles; load asserted on the boundary cycle is displayed in the very next frame.
REQ-038 rst asserted mid-frame with pending_valid=1 -> next cycle an=1111, seg=FF; the pending value is never displayed and shadow=0 (seg=C0 on digit 0).

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous double buffering,
// leading-zero suppression and selectable output polarity.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      enable,
  input  logic                      lz_blank,
  output logic [7:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic                  POL      = (ACTIVE_LOW != 0);
  localparam logic [7:0]            SEG_POL  = {8{POL}};
  localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{POL}};

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  frame_done_d;

  logic                  tick_c;
  logic                  boundary_c;

  // Active-high a..g pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg          <= SEG_POL;
      an           <= AN_POL;
      frame_done   <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg          <= seg_d;
      an           <= an_d;
      frame_done   <= frame_done_d;
    end
  end

  // Scan counters and the pending -> shadow handoff at the frame boundary
  always_comb begin
    tick_c       = enable && (presc_q == PRE_LAST);
    boundary_c   = tick_c && (idx_q == IDX_LAST);
    presc_d      = presc_q;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    if (!enable) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (tick_c) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : IDX_W'(idx_q + 1'b1);
    end else begin
      presc_d = PRE_W'(presc_q + 1'b1);
    end

    if (boundary_c) begin
      // A load landing on the boundary bypasses pending entirely
      if (load) begin
        shadow_val_d = value;
        shadow_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        shadow_val_d = pend_val_q;
        shadow_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  // Next output values, built active-high then polarity-adjusted
  logic [3:0]            nib_c [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_above_c;
  logic                  all_zero_c;
  logic                  suppress_c;

  always_comb begin
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      nib_c[i] = shadow_val_q[4*i +: 4];
    end
    all_zero_c = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero_c      = all_zero_c & (nib_c[i] == 4'h0);
      zero_above_c[i] = all_zero_c;
    end
    suppress_c = lz_blank && (idx_q != '0) && zero_above_c[idx_q];

    seg_d        = 8'h00;
    an_d         = '0;
    frame_done_d = boundary_c;
    if (enable) begin
      seg_d = {shadow_dp_q[idx_q], suppress_c ? 7'h00 : hex_to_seg(nib_c[idx_q])};
      an_d  = NUM_DIGITS'(1) << idx_q;
    end
    seg_d = seg_d ^ SEG_POL;
    an_d  = an_d ^ AN_POL;
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: a cycle-count reference model predicts
// every output cycle; a monitor pops and compares on the falling edge.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic          load = 1'b0;
  logic          enable = 1'b0;
  logic          lz_blank = 1'b0;
  logic [7:0]    seg;
  logic [3:0]    an;
  logic          frame_done;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .enable(enable), .lz_blank(lz_blank), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   done  = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position in the scan is simply the count of enabled cycles
  initial begin
    int          c;
    bit          started;
    logic [15:0] sh_v, pd_v;
    logic [3:0]  sh_dp, pd_dp;
    bit          pv;
    exp_t        e;
    c = 0; started = 0; sh_v = 0; pd_v = 0; sh_dp = 0; pd_dp = 0; pv = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) started = 1;
      if (started) begin
        bit boundary;
        boundary = 0;
        if (rst) begin
          e = '{seg: 8'hFF, an: 4'hF, fd: 1'b0};
          c = 0; sh_v = 0; sh_dp = 0; pd_v = 0; pd_dp = 0; pv = 0;
        end else begin
          if (enable) begin
            int   d;
            logic [6:0] s7;
            d = (c / RD) % N;
            boundary = ((c % (RD * N)) == RD * N - 1);
            s7 = hex_tab[(sh_v >> (4 * d)) & 16'hF];
            if (lz_blank && d > 0 && (sh_v >> (4 * d)) == 0) s7 = 7'h00;
            e.seg = ~{sh_dp[d], s7};
            e.an  = ~(4'(1) << d);
            e.fd  = boundary;
            c++;
          end else begin
            e = '{seg: 8'hFF, an: 4'hF, fd: 1'b0};
            c = 0;
          end
          if (boundary) begin
            if (load) begin sh_v = value; sh_dp = dp_in; end
            else if (pv) begin sh_v = pd_v; sh_dp = pd_dp; end
            pv = 0;
          end else if (load) begin
            pd_v = value; pd_dp = dp_in; pv = 1;
          end
        end
        sb.push_back(e);
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({seg, an, frame_done} !== e) begin
          n_bad++;
          $display("FAIL scoreboard cyc=%0d got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                   cyc, seg, an, frame_done, e.seg, e.an, e.fd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_fd(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s frame_done timeout got 0 want 1", name);
    end
  endtask

  initial begin
    logic [7:0] demo [4];
    demo[0] = 8'h99; demo[1] = 8'hB0; demo[2] = 8'hA4; demo[3] = 8'hF9;

    repeat (2) @(negedge clk);
    check("reset_out", {seg, an}, {8'hFF, 4'hF});

    // Load 1234 and observe the first full frame
    rst = 0; enable = 1; load = 1; value = 16'h1234; dp_in = 4'h0;
    @(negedge clk);
    load = 0;
    wait_fd("first_frame");
    for (int d = 0; d < N; d++) begin
      for (int r = 0; r < RD; r++) begin
        logic [3:0] an_w;
        an_w = ~(4'(1) << d);
        @(negedge clk);
        check($sformatf("demo_d%0d_r%0d", d, r), {seg, an}, {demo[d], an_w});
      end
    end

    // Load exactly on the boundary cycle shows in the very next frame
    wait_fd("period_start");
    repeat (15) @(negedge clk);
    load = 1; value = 16'hABCD;
    @(negedge clk);
    load = 0;
    check("fd_period16", {11'h0, frame_done}, 12'h001);
    @(negedge clk);
    check("boundary_load", {seg, an}, {8'hA1, 4'hE});

    // Randomised traffic
    for (int k = 0; k < 4000; k++) begin
      int m;
      @(negedge clk);
      rst  = ($urandom_range(0, 599) == 0);
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        m = $urandom_range(0, 3);
        value = 16'($urandom) & ((m == 0) ? 16'hFFFF : (m == 1) ? 16'h00FF : (m == 2) ? 16'h000F : 16'h0000);
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) lz_blank = ~lz_blank;
    end
    @(negedge clk);
    rst = 0; load = 0;
    repeat (3) @(negedge clk);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
